pipe_alu_mem_p: RTL and testbench

- Parametrised, single-clock successor to the two-phase register-ALU-memory pipeline (pipe_ex2).
- Four stages: operand fetch, ALU, register write-back with result output, memory store.
- Adds valid qualification, asynchronous reset, register-bank initialisation, data forwarding between back-to-back dependent operations, and a memory read port for checking.

---
 rtl/pipe_alu_mem_p_if.sv | 47 ++++
 rtl/pipe_alu_mem_p.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_alu_mem_p.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_alu_mem_p_if.sv
// pipe_alu_mem_p_if
// -----------------
// Purpose: groups the operation-issue, result and debug-read signals of
// pipe_alu_mem_p into one bundle. clk and rst stay as plain ports on the
// design itself.
//
// Signal summary (directions seen from the slave, i.e. the pipeline):
//   in_valid  in   operation present this cycle
//   rs1, rs2  in   source register indices (REG_AW bits)
//   rd        in   destination register index (REG_AW bits)
//   func      in   ALU operation code (4 bits)
//   addr      in   memory store address (MEM_AW bits)
//   z         out  registered result of the most recent completed operation
//   z_valid   out  one-cycle pulse marking a z update
//   mem_raddr in   debug read address
//   mem_rdata out  combinational read of mem[mem_raddr]
//
// Handshake: in_valid is a pure qualifier with no ready. Whenever in_valid is
// high at a rising clk edge the pipeline accepts the operation unconditionally
// (there are no stalls and no backpressure); in_valid low inserts a bubble.
// z_valid is likewise a one-cycle qualifier for z with no acknowledge.
interface pipe_alu_mem_p_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) ();
  logic              in_valid;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [3:0]        func;
  logic [MEM_AW-1:0] addr;
  logic [DATA_W-1:0] z;
  logic              z_valid;
  logic [MEM_AW-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output in_valid, rs1, rs2, rd, func, addr, mem_raddr,
    input  z, z_valid, mem_rdata
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, func, addr, mem_raddr,
    output z, z_valid, mem_rdata
  );
endinterface

// File: rtl/pipe_alu_mem_p.sv
// pipe_alu_mem_p
// --------------
// Purpose: four-stage register/ALU/memory pipeline, one operation per cycle.
//   S1 operand fetch : read regbank[rs1], regbank[rs2] (with write-through
//                      bypass from the result being written this edge).
//   S2 ALU           : compute result, forwarding the previous op's result
//                      when it targets one of this op's sources.
//   S3 write-back    : regbank[rd] <= result, z <= result, z_valid pulse.
//   S4 memory store  : mem[addr] <= z.
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous, active-high reset (sync release expected)
//   bus  pipe_alu_mem_p_if.slave: in_valid, rs1, rs2, rd, func, addr,
//        z, z_valid, mem_raddr, mem_rdata
//
// Optional feature: define PIPE_ALU_SAT_EN to make codes 0 (add), 1 (sub),
// 8 (-A) and 9 (-B) saturate as signed two's-complement. Without the macro
// every code wraps modulo 2**DATA_W and no saturation logic is built.
//
// Reset clears all stage valids, z and z_valid, and reloads regbank[k] = k.
// Data memory is never reset.
module pipe_alu_mem_p #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  pipe_alu_mem_p_if.slave  bus
);
  localparam int NREG = 1 << REG_AW;
  localparam int NMEM = 1 << MEM_AW;

  // Architectural state
  logic [DATA_W-1:0] regbank_q [NREG];
  logic [DATA_W-1:0] mem_q     [NMEM];

  // S1: fetched operands and op fields
  logic              s1_v_q;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  logic [REG_AW-1:0] s1_rs1_q;
  logic [REG_AW-1:0] s1_rs2_q;
  logic [REG_AW-1:0] s1_rd_q;
  logic [3:0]        s1_func_q;
  logic [MEM_AW-1:0] s1_addr_q;

  // S2: ALU result
  logic              s2_v_q;
  logic [DATA_W-1:0] s2_res_q, s2_res_d;
  logic [REG_AW-1:0] s2_rd_q;
  logic [MEM_AW-1:0] s2_addr_q;

  // S3: write-back / result output (s3_v_q doubles as z_valid)
  logic              s3_v_q;
  logic [DATA_W-1:0] z_q;
  logic [MEM_AW-1:0] s3_addr_q;

  // ALU operands after forwarding
  logic [DATA_W-1:0] alu_a, alu_b;

`ifdef PIPE_ALU_SAT_EN
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Signed add/sub on a sign-extended copy: overflow shows up as the two top
  // bits disagreeing, and the extra top bit gives the true sign to clamp to.
  function automatic logic [DATA_W-1:0] sat_addsub(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y,
    input logic              sub
  );
    logic [DATA_W:0] ext;
    if (sub) ext = {x[DATA_W-1], x} - {y[DATA_W-1], y};
    else     ext = {x[DATA_W-1], x} + {y[DATA_W-1], y};
    if (ext[DATA_W] != ext[DATA_W-1]) begin
      return ext[DATA_W] ? SMIN : SMAX;
    end
    return ext[DATA_W-1:0];
  endfunction
`endif

  // ---------------------------------------------------------------------
  // S1 operand fetch with write-through bypass: the op in S2 writes the
  // regbank on this same edge, so its result must replace the stale read.
  // ---------------------------------------------------------------------
  always_comb begin
    s1_a_d = regbank_q[bus.rs1];
    s1_b_d = regbank_q[bus.rs2];
    if (s2_v_q && (s2_rd_q == bus.rs1)) s1_a_d = s2_res_q;
    if (s2_v_q && (s2_rd_q == bus.rs2)) s1_b_d = s2_res_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_rs1_q  <= '0;
      s1_rs2_q  <= '0;
      s1_rd_q   <= '0;
      s1_func_q <= '0;
      s1_addr_q <= '0;
    end else begin
      s1_v_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s1_rs1_q  <= bus.rs1;
        s1_rs2_q  <= bus.rs2;
        s1_rd_q   <= bus.rd;
        s1_func_q <= bus.func;
        s1_addr_q <= bus.addr;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S2 ALU. Forwarding covers the back-to-back case: the op now in S2 was
  // fetched one cycle too late to see the previous op's result.
  // ---------------------------------------------------------------------
  always_comb begin
    alu_a = s1_a_q;
    alu_b = s1_b_q;
    if (s2_v_q && (s2_rd_q == s1_rs1_q)) alu_a = s2_res_q;
    if (s2_v_q && (s2_rd_q == s1_rs2_q)) alu_b = s2_res_q;
  end

  always_comb begin
    s2_res_d = '0;
    unique case (s1_func_q)
`ifdef PIPE_ALU_SAT_EN
      4'd0:  s2_res_d = sat_addsub(alu_a, alu_b, 1'b0);
      4'd1:  s2_res_d = sat_addsub(alu_a, alu_b, 1'b1);
      4'd8:  s2_res_d = sat_addsub('0, alu_a, 1'b1);
      4'd9:  s2_res_d = sat_addsub('0, alu_b, 1'b1);
`else
      4'd0:  s2_res_d = alu_a + alu_b;
      4'd1:  s2_res_d = alu_a - alu_b;
      4'd8:  s2_res_d = -alu_a;
      4'd9:  s2_res_d = -alu_b;
`endif
      4'd2:  s2_res_d = alu_a * alu_b;
      4'd3:  s2_res_d = alu_a;
      4'd4:  s2_res_d = alu_b;
      4'd5:  s2_res_d = alu_a & alu_b;
      4'd6:  s2_res_d = alu_a | alu_b;
      4'd7:  s2_res_d = alu_a ^ alu_b;
      4'd10: s2_res_d = alu_a >> 1;
      4'd11: s2_res_d = alu_a << 1;
      default: s2_res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q    <= 1'b0;
      s2_res_q  <= '0;
      s2_rd_q   <= '0;
      s2_addr_q <= '0;
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_res_q  <= s2_res_d;
        s2_rd_q   <= s1_rd_q;
        s2_addr_q <= s1_addr_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S3 write-back. Bubbles leave z and the regbank untouched.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        regbank_q[k] <= DATA_W'(k);
      end
      s3_v_q    <= 1'b0;
      z_q       <= '0;
      s3_addr_q <= '0;
    end else begin
      s3_v_q <= s2_v_q;
      if (s2_v_q) begin
        regbank_q[s2_rd_q] <= s2_res_q;
        z_q                <= s2_res_q;
        s3_addr_q          <= s2_addr_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S4 memory store. No reset on the array; s3_v_q is cleared by reset, so
  // an op caught in flight never completes its store.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (s3_v_q) begin
      mem_q[s3_addr_q] <= z_q;
    end
  end

  assign bus.z         = z_q;
  assign bus.z_valid   = s3_v_q;
  assign bus.mem_rdata = mem_q[bus.mem_raddr];

endmodule

// File: tb/tb_pipe_alu_mem_p.sv
// tb_pipe_alu_mem_p
// -----------------
// Bench for pipe_alu_mem_p. The reference model executes each issued op
// immediately and in program order against its own register and memory
// arrays; expected z values then wait in a queue for the pipeline latency.
module tb_pipe_alu_mem_p;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int MEM_AW = 8;
  localparam int NREG   = 1 << REG_AW;
  localparam int NMEM   = 1 << MEM_AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_alu_mem_p_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) bus ();

  pipe_alu_mem_p #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;
  int pulses;

  logic [DATA_W-1:0] m_regs  [NREG];
  logic [DATA_W-1:0] m_mem   [NMEM];
  bit                m_known [NMEM];

  logic [DATA_W-1:0] exp_q   [$];   // expected result per issued slot
  bit                exp_v_q [$];   // slot carried a valid op
  int                exp_a_q [$];   // slot store address

  bit                pend_v;        // store due on the edge after z update
  int                pend_a;
  logic [DATA_W-1:0] pend_r;
  logic [DATA_W-1:0] exp_z;

  // Spec-level ALU using plain integer arithmetic.
  function automatic logic [DATA_W-1:0] model_alu(input int f, input longint a, input longint b);
    longint full;
    longint half;
    longint sa;
    longint sb;
    longint r;
    full = longint'(1) << DATA_W;
    half = full / 2;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    case (f)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a * b;
      3:  r = a;
      4:  r = b;
      5:  r = a & b;
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = -a;
      9:  r = -b;
      10: r = a / 2;
      11: r = a * 2;
      default: r = 0;
    endcase
`ifdef PIPE_ALU_SAT_EN
    if (f == 0 || f == 1 || f == 8 || f == 9) begin
      case (f)
        0: r = sa + sb;
        1: r = sa - sb;
        8: r = -sa;
        default: r = -sb;
      endcase
      if (r > half - 1) r = half - 1;
      if (r < -half)    r = -half;
    end
`else
    sa = sa + sb;  // signed views only matter with saturation
`endif
    r = r % full;
    if (r < 0) r = r + full;
    return DATA_W'(r);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) m_regs[k] = DATA_W'(k);
    exp_q.delete();
    exp_v_q.delete();
    exp_a_q.delete();
    // Two empty slots stand for the S1/S2 stages after reset.
    repeat (2) begin
      exp_q.push_back('0);
      exp_v_q.push_back(1'b0);
      exp_a_q.push_back(0);
    end
    pend_v = 1'b0;
    exp_z  = '0;
  endtask

  // ---------------- driver ----------------
  // Issues one slot at the falling edge, then checks z/z_valid 1 ns after
  // the following rising edge against the slot issued two edges earlier.
  task automatic step(input bit v, input int s1, input int s2, input int d,
                      input int f, input int ad);
    logic [DATA_W-1:0] res;
    bit                ev;
    logic [DATA_W-1:0] er;
    int                ea;
    @(negedge clk);
    if (pend_v) begin
      m_mem[pend_a]   = pend_r;
      m_known[pend_a] = 1'b1;
    end
    pend_v = 1'b0;
    bus.in_valid = v;
    bus.rs1  = REG_AW'(s1);
    bus.rs2  = REG_AW'(s2);
    bus.rd   = REG_AW'(d);
    bus.func = 4'(f);
    bus.addr = MEM_AW'(ad);
    res = '0;
    if (v) begin
      res = model_alu(f, longint'(m_regs[s1]), longint'(m_regs[s2]));
      m_regs[d] = res;
    end
    exp_q.push_back(res);
    exp_v_q.push_back(v);
    exp_a_q.push_back(ad);
    @(posedge clk);
    #1;
    ev = exp_v_q.pop_front();
    er = exp_q.pop_front();
    ea = exp_a_q.pop_front();
    if (ev) begin
      exp_z  = er;
      pend_v = 1'b1;
      pend_a = ea;
      pend_r = er;
    end
    total++;
    if (bus.z_valid !== ev) begin
      bad++;
      $display("FAIL z_valid: got %b want %b at %0t", bus.z_valid, ev, $time);
    end
    total++;
    if (bus.z !== exp_z) begin
      bad++;
      $display("FAIL z: got %h want %h at %0t", bus.z, exp_z, $time);
    end
    if (bus.z_valid === 1'b1) pulses++;
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_mem(input int a);
    bus.mem_raddr = MEM_AW'(a);
    #1;
    if (m_known[a]) begin
      total++;
      if (bus.mem_rdata !== m_mem[a]) begin
        bad++;
        $display("FAIL mem[%0d]: got %h want %h", a, bus.mem_rdata, m_mem[a]);
      end
    end
  endtask

  // Compares memory against the fixed values the legacy sequence leaves.
  task automatic check_legacy_mem(input string tag);
    logic [DATA_W-1:0] leg [6];
    leg[0] = 16'd8;  leg[1] = 16'd65534; leg[2] = 16'd35;
    leg[3] = 16'd6;  leg[4] = 16'd9;     leg[5] = 16'd8;
    for (int i = 0; i < 6; i++) begin
      bus.mem_raddr = MEM_AW'(125 + i);
      #1;
      total++;
      if (bus.mem_rdata !== leg[i]) begin
        bad++;
        $display("FAIL %s mem[%0d]: got %h want %h", tag, 125 + i, bus.mem_rdata, leg[i]);
      end
    end
  endtask

  task automatic check_z_const(input string tag, input logic [DATA_W-1:0] want);
    total++;
    if (bus.z !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, bus.z, want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.func = '0; bus.addr = '0;
    bus.mem_raddr = '0;
    for (int i = 0; i < NMEM; i++) m_known[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.z !== '0) begin
      bad++;
      $display("FAIL reset z: got %h want 0", bus.z);
    end
    total++;
    if (bus.z_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset z_valid: got %b want 0", bus.z_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_legacy();
    pulses = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 3 + i, 5 + i, 10 + i, i, 125 + i);
    drain();
    total++;
    if (pulses != 6) begin
      bad++;
      $display("FAIL legacy pulses: got %0d want 6", pulses);
    end
    check_legacy_mem("legacy");
    // Read regbank[10] back through op code 3 (result = A).
    step(1'b1, 10, 0, 10, 3, 200);
    drain();
    check_z_const("legacy regbank10", 16'd8);
  endtask

  task automatic test_dist1();
    step(1'b1, 1, 2, 3, 0, 40);
    step(1'b1, 3, 3, 4, 0, 41);
    step(1'b0, 0, 0, 0, 0, 0);
    check_z_const("dist1 first", 16'd3);
    step(1'b0, 0, 0, 0, 0, 0);
    check_z_const("dist1 second", 16'd6);
    step(1'b1, 4, 4, 7, 3, 42);
    drain();
    check_z_const("dist1 regbank4", 16'd6);
  endtask

  task automatic test_dist2();
    step(1'b1, 1, 2, 5, 0, 43);
    step(1'b0, 0, 0, 0, 0, 0);
    step(1'b1, 5, 1, 6, 1, 44);
    drain();
    check_z_const("dist2", 16'd2);
  endtask

  task automatic test_bubbles();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        step(1'b1, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
             $urandom_range(0, NREG - 1), $urandom_range(0, 11), 46 + i);
      else
        step(1'b0, 1, 2, 3, 0, 125 + (i % 6));
    end
    drain();
    total++;
    if (pulses != 4) begin
      bad++;
      $display("FAIL bubbles pulses: got %0d want 4", pulses);
    end
    check_legacy_mem("bubbles");
    for (int i = 46; i < 54; i++) check_mem(i);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
           $urandom_range(0, NREG - 1), $urandom_range(0, 15),
           $urandom_range(0, 63));
    end
    drain();
    for (int i = 0; i < 64; i++) check_mem(i);
  endtask

  task automatic test_reset_midflight();
    // Result 0 differs from what the legacy run left at 125..127.
    step(1'b1, 1, 2, 3, 12, 125);
    step(1'b1, 2, 3, 4, 12, 126);
    step(1'b1, 3, 4, 5, 12, 127);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.z !== '0) begin
      bad++;
      $display("FAIL midflight z: got %h want 0", bus.z);
    end
    total++;
    if (bus.z_valid !== 1'b0) begin
      bad++;
      $display("FAIL midflight z_valid: got %b want 0", bus.z_valid);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    drain();
    check_legacy_mem("midflight");
    // Every register must read back its own index.
    for (int k = 0; k < NREG; k++) step(1'b1, k, k, k, 3, 80 + k);
    drain();
    for (int k = 80; k < 80 + NREG; k++) check_mem(k);
  endtask

  task automatic test_sat();
    logic [DATA_W-1:0] want;
    step(1'b1, 1, 1, 2, 8, 100);   // r2 = -1
    step(1'b1, 2, 2, 3, 10, 101);  // r3 = 0x7FFF
    step(1'b1, 3, 1, 4, 0, 102);   // r3 + r1
    drain();
`ifdef PIPE_ALU_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'h8000;
`endif
    check_z_const("sat add", want);
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_dist1();
    test_dist2();
    test_bubbles();
    test_random();
    test_reset_midflight();
    test_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
